// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch slice.
package fetch_unit_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [31:0] NOP = 32'h0000_0013;

    // Major opcodes already consumed by immediate decode
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response bus.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_gnt, imem_rvalid, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_gnt, imem_rvalid, imem_rdata);
endinterface

// File: rtl/fetch_fifo.sv
// Small circular FIFO with flush; head is visible combinationally.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (do_pop) rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues sequential word fetches, queues responses for decode,
// and squashes in-flight responses on redirect.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    fetch_unit_if.master        imem,
    input  logic                redirect,
    input  logic [31:0]         redirect_pc,
    output logic                inst_valid,
    output logic [31:0]         inst,
    output logic [31:0]         inst_pc,
    input  logic                inst_ready,
    output logic                fetch_err
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned LW = CW + 1;

    fetch_state_t  state;
    logic [31:0]   pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic [CW-1:0] q_count;
    logic [CW-1:0] out_next;
    logic          rsp_ok;
    logic          grant;
    logic          push;
    logic          pop;
    logic          flush;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;

    assign imem.imem_req  = (state == ST_RUN) && !redirect &&
                            ((LW'(q_count) + LW'(outstanding)) < LW'(DEPTH));
    assign imem.imem_addr = pc;

    assign rsp_ok   = imem.imem_rvalid && (outstanding != '0);
    assign grant    = imem.imem_req && imem.imem_gnt;
    assign out_next = outstanding + CW'(grant) - CW'(rsp_ok);
    assign flush    = (state == ST_RUN) && redirect;
    assign push     = rsp_ok && (state == ST_RUN) && !redirect && (drop == '0);
    assign pop      = inst_valid && inst_ready && !redirect;

    // Non-dropped requests are contiguous and end just below pc
    assign push_entry.inst = imem.imem_rdata;
    assign push_entry.pc   = pc - (32'(outstanding) << 2);

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .flush (flush),
        .dout  (head),
        .count (q_count)
    );

    assign inst_valid = (q_count != '0);
    assign inst       = head.inst;
    assign inst_pc    = head.pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_BOOT;
            pc          <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            fetch_err   <= 1'b0;
        end else begin
            outstanding <= out_next;
            if (grant) pc <= pc + 32'd4;
            if ((drop != '0) && rsp_ok) drop <= drop - CW'(1);
            case (state)
                ST_BOOT: state <= ST_RUN;
                ST_RUN: begin
                    if (redirect) begin
                        drop <= out_next;
                        if (misaligned(redirect_pc[1:0])) begin
                            state     <= ST_HALT;
                            fetch_err <= 1'b1;
                        end else begin
                            pc <= redirect_pc;
                        end
                    end
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit against a queue-based reference model.
module tb_fetch_unit;
    localparam int unsigned DEPTH   = 2;
    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam logic [31:0] RST_PC2 = 32'hFFFF_FFFC;
    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        fetch_err;

    logic        redirect2;
    logic [31:0] rpc2;
    logic        valid2;
    logic [31:0] inst2;
    logic [31:0] ipc2;
    logic        ready2;
    logic        err2;

    fetch_unit_if bus();
    fetch_unit_if bus2();

    fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .imem(bus), .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
        .fetch_err(fetch_err)
    );

    fetch_unit #(.RESET_PC(RST_PC2), .DEPTH(DEPTH)) dut2 (
        .clk(clk), .rst_n(rst_n), .imem(bus2), .redirect(redirect2), .redirect_pc(rpc2),
        .inst_valid(valid2), .inst(inst2), .inst_pc(ipc2), .inst_ready(ready2),
        .fetch_err(err2)
    );

    typedef struct { logic [31:0] addr; bit doomed; } req_t;
    typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;

    req_t        oq[$];
    ent_t        iq[$];
    logic [31:0] mem_q[$];
    int          mode;
    logic [31:0] pc_m;
    logic        err_m;
    int          since_rst = 1000;
    bit          last_grant;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        iq.delete();
        oq.delete();
        mode      = M_BOOT;
        pc_m      = RST_PC;
        err_m     = 1'b0;
        since_rst = 0;
    endtask

    // One clock cycle: drive, compare against model, advance model and memory.
    task automatic cyc(input bit r, input bit g, input bit rv, input bit rd,
                       input logic [31:0] rp, input bit rdy);
        bit   e_req;
        bit   acc;
        req_t e;
        rst_n            = r;
        bus.imem_gnt     = g;
        bus.imem_rvalid  = rv;
        bus.imem_rdata   = (mem_q.size() > 0) ? mem_q[0] : $urandom();
        redirect         = rd;
        redirect_pc      = rp;
        inst_ready       = rdy;
        #4;
        e_req = (mode == M_RUN) && !rd && ((iq.size() + oq.size()) < DEPTH);
        chk("imem_req", 32'(bus.imem_req), 32'(e_req));
        chk("imem_addr", bus.imem_addr, pc_m);
        chk("inst_valid", 32'(inst_valid), 32'(iq.size() > 0));
        if (iq.size() > 0) begin
            chk("inst", inst, iq[0].inst);
            chk("inst_pc", inst_pc, iq[0].pc);
        end
        chk("fetch_err", 32'(fetch_err), 32'(err_m));
        if (since_rst == 0) begin
            chk("wrap_boot_req", 32'(bus2.imem_req), 32'd0);
            chk("wrap_boot_err", 32'(err2), 32'd0);
            chk("wrap_boot_valid", 32'(valid2), 32'd0);
        end else if (since_rst == 1) begin
            chk("wrap_req1", 32'(bus2.imem_req), 32'd1);
            chk("wrap_addr1", bus2.imem_addr, RST_PC2);
        end else if (since_rst == 2) begin
            chk("wrap_req2", 32'(bus2.imem_req), 32'd1);
            chk("wrap_addr2", bus2.imem_addr, 32'h0000_0000);
        end
        last_grant = bus.imem_req && g;

        if (!r) begin
            model_reset();
        end else begin
            if (since_rst < 1000) since_rst++;
            acc = rv && (oq.size() > 0);
            if (acc) e = oq.pop_front();
            if (mode == M_RUN && rd) begin
                iq.delete();
                foreach (oq[i]) oq[i].doomed = 1'b1;
                if (rp[1:0] != 2'b00) begin
                    mode  = M_HALT;
                    err_m = 1'b1;
                end else begin
                    pc_m = rp;
                end
            end else begin
                if (iq.size() > 0 && rdy) void'(iq.pop_front());
                if (acc && !e.doomed && mode == M_RUN)
                    iq.push_back('{inst: bus.imem_rdata, pc: e.addr});
                if (e_req && g) begin
                    oq.push_back('{addr: pc_m, doomed: 1'b0});
                    pc_m = pc_m + 32'd4;
                end
            end
            if (mode == M_BOOT) mode = M_RUN;
        end

        if (!r) begin
            mem_q.delete();
        end else begin
            if (rv && mem_q.size() > 0) void'(mem_q.pop_front());
            if (last_grant) mem_q.push_back($urandom());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] seen[$];
        int          n;
        bit          found;
        int          halt_cycles;
        bit          r;
        bit          rd;
        logic [31:0] rp;

        bus2.imem_gnt    = 1'b1;
        bus2.imem_rvalid = 1'b0;
        bus2.imem_rdata  = 32'h0;
        redirect2        = 1'b0;
        rpc2             = 32'h0;
        ready2           = 1'b1;

        // Power-on reset
        rst_n           = 1'b0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        redirect        = 1'b0;
        redirect_pc     = 32'h0;
        inst_ready      = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_err", 32'(fetch_err), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);

        // Streaming with gnt=1, 1-cycle memory latency, ready=1
        for (int i = 0; i < 12; i++) begin
            cyc(1, 1, mem_q.size() > 0, 0, 32'h0, 1);
            if (inst_valid) seen.push_back(inst_pc);
        end
        chk("stream_count", 32'(seen.size() >= 3), 32'd1);
        if (seen.size() >= 3) begin
            chk("stream_pc0", seen[0], 32'h0);
            chk("stream_pc1", seen[1], 32'h4);
            chk("stream_pc2", seen[2], 32'h8);
        end

        // Backpressure: exactly DEPTH grants while decode stalls
        cyc(0, 0, 0, 0, 32'h0, 0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1, 1, 0, 0, 32'h0, 0);
            if (last_grant) n++;
        end
        chk("stall_grants", 32'(n), 32'd2);
        for (int i = 0; i < 3; i++) cyc(1, 1, mem_q.size() > 0, 0, 32'h0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 1, mem_q.size() > 0, 0, 32'h0, 1);

        // Aligned redirect with one request in flight
        cyc(0, 0, 0, 0, 32'h0, 0);
        cyc(1, 1, 0, 0, 32'h0, 0);
        cyc(1, 1, 0, 0, 32'h0, 0);
        cyc(1, 1, 1, 1, 32'h0000_0100, 0);
        for (int i = 0; i < 4; i++) cyc(1, 1, mem_q.size() > 0, 0, 32'h0, 0);
        chk("redir_valid", 32'(inst_valid), 32'd1);
        chk("redir_pc", inst_pc, 32'h0000_0100);

        // Misaligned redirect halts fetch until reset
        cyc(1, 1, mem_q.size() > 0, 1, 32'h0000_0102, 1);
        for (int i = 0; i < 5; i++) begin
            chk("halt_err", 32'(fetch_err), 32'd1);
            chk("halt_req", 32'(bus.imem_req), 32'd0);
            chk("halt_valid", 32'(inst_valid), 32'd0);
            cyc(1, 1, mem_q.size() > 0, (i == 2), 32'h0000_0200, 1);
        end

        // Reset mid-stream followed by a stale response
        cyc(0, 0, 0, 0, 32'h0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 1, mem_q.size() > 0, 0, 32'h0, 1);
        cyc(0, 1, mem_q.size() > 0, 0, 32'h0, 1);
        cyc(1, 1, 1, 0, 32'h0, 0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc(1, 1, mem_q.size() > 0, 0, 32'h0, 0);
            found = inst_valid;
        end
        chk("stale_found", 32'(found), 32'd1);
        chk("stale_first_pc", inst_pc, RST_PC);

        // Randomized traffic
        halt_cycles = 0;
        for (int i = 0; i < 3000; i++) begin
            halt_cycles = (mode == M_HALT) ? halt_cycles + 1 : 0;
            r  = !((halt_cycles > 8) || ($urandom_range(0, 199) == 0));
            rd = ($urandom_range(0, 19) == 0);
            rp = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) rp = 32'hFFFF_FFF8;
            if ($urandom_range(0, 5) == 0) rp[1:0] = 2'($urandom_range(1, 3));
            cyc(r, $urandom_range(0, 3) != 0,
                (mem_q.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0),
                rd, rp, $urandom_range(0, 2) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
